lane_receptor: RTL and testbench
================================

# lane_receptor

Parametrised receptor stage for the note highway: N lanes, multi-key rollover, registered press/release edge pulses, and a per-lane frame-timed flash. It sits between the USB keycode PIO and the color mapper. It supplies held/press/release lane state to the judging logic and per-pixel receptor and lane-background hit flags to the color mapper.

## Interface
- NUM_LANES, 4: number of lanes; lane 0 is leftmost.
- NUM_KEYS, 2: simultaneous keycode slots from the keyboard report.
- LANE_KEYS, {8'h3b,8'h35,8'h33,8'h34}: packed NUM_LANES×8 keycode map; lane i uses bits [8i+7:8i]. Default order is left, down, up, right.
- LANE_X0, 256: left pixel column of lane 0.
- LANE_W, 32: lane width in pixels.
- REC_Y0, 30: receptor top row.
- REC_H, 50: receptor height in rows.
- FLASH_FRAMES, 6: frames a receptor stays lit after a press; 1..255.
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (vsync edge, already synchronised to Clk).
- keycodes  in  8×NUM_KEYS  keycode slots; 8'h00 means empty.
- DrawX, DrawY  in  10 each  current pixel.
- key_held  out  NUM_LANES  registered level: lane key is down.
- key_press  out  NUM_LANES  one-cycle pulse on the press edge.
- key_release  out  NUM_LANES  one-cycle pulse on the release edge.
- is_receptor  out  NUM_LANES  pixel is inside lane i's receptor box and lane i is lit.
- flash_level  out  8  remaining flash count of the lane under DrawX; 0 outside the lanes.
- is_background, is_receptor_background  out  1 each  pixel is in the lane band / in the receptor row band.

## Operation
- Match: lane i is matched when any keycode slot equals LANE_KEYS[i] and that slot is nonzero. A key duplicated across slots counts once. Lanes that share a keycode all match.
- held register: held[i] <= match[i] on every Clk.
  - key_press = match & ~held, registered.
  - key_release = ~match & held, registered.
- Flash counter: 8-bit cnt[i] per lane.
  - Press edge: load FLASH_FRAMES.
  - Otherwise, on frame_tick: decrement if nonzero.
  - Saturates at 0.
  - A press edge and frame_tick in the same cycle: the load wins.
- Lit condition: lit[i] = held[i] | (cnt[i] != 0).
- Lane index and geometry:
  - Lane index = (DrawX − LANE_X0) / LANE_W; use a shift when LANE_W is a power of two.
  - The pixel is in the band when LANE_X0 ≤ DrawX ≤ LANE_X0 + NUM_LANES·LANE_W − 1.
  - The pixel is in the receptor rows when REC_Y0 ≤ DrawY ≤ REC_Y0 + REC_H − 1.
  - Compare in 11-bit unsigned so the edges never wrap.
- Pixel outputs:
  - is_background = in band.
  - is_receptor_background = in band and in receptor rows.
  - is_receptor[i] = in band, in receptor rows, lane index = i, and lit[i].
  - At most one bit of is_receptor is set.
- Reset: held, key_press, key_release, all cnt, and every pixel output go to 0. Asserting reset mid-flash clears the flash immediately. No release pulse is issued for keys that were held at reset.

## Timing
- Key path:
  - keycodes change at edge k.
  - key_press and key_held are visible after edge k+1.
  - key_press is high for exactly one cycle.
- Flash:
  - cnt = FLASH_FRAMES starting the cycle after the press pulse.
  - The receptor stays lit through FLASH_FRAMES frame_ticks after release.
  - A key held longer than the flash stays lit while held.
- Pixel path: all pixel outputs are registered, with 1 Clk latency from DrawX/DrawY. The color mapper delays its own pixel by 1 cycle to match.
- Re-press during a flash reloads the counter and produces a new press pulse.
- A keycode that changes slot while the key is still held produces no pulses.

## Structure
- The stepmania_pkg package holds:
  - localparams for the default lane keycodes (KEY_LEFT=8'h34, KEY_DOWN=8'h33, KEY_UP=8'h35, KEY_RIGHT=8'h3b);
  - the default geometry constants;
  - typedef lane_mask_t = logic [NUM_LANES-1:0].
- One sub-module, lane_flash: a single lane's held/edge/counter logic, instantiated NUM_LANES times in a generate loop.
- The top level contains the keycode match and the registered pixel geometry.

## Test plan
- Reset with keycodes={8'h34,0}, then release Reset_n → all outputs 0. The cycle after the first post-reset edge: key_press=4'b0001 for one cycle, key_held=4'b0001.
- keycodes={8'h33,8'h3b} arriving together → key_press=4'b1010 in the same cycle. Later keycodes={8'h3b,0} → key_release=4'b0010, key_held=4'b1000.
- Press then release lane 2 with FLASH_FRAMES=6, then apply 6 frame_ticks → flash_level at DrawX=330 goes 6…0. Pixel (330,50) gives is_receptor=4'b0100 until the 6th tick, then 0.
- Press edge coinciding with frame_tick while cnt=2 → cnt=6, not 1.
- Geometry sweep at DrawY=30/79/80 and DrawX=255/256/287/288/383/384 → correct band boundaries. Lane-index change occurs at 288. All pixel outputs show exactly 1-cycle latency.
- Assert Reset_n low while lane 0 is held and flashing → outputs cleared asynchronously. After release with the key still down → one fresh press pulse.

Source files
------------

// File: rtl/stepmania_pkg.sv
// Shared constants and types for the note-highway receptor stage:
// default lane keycodes, default geometry and a small helper for lane indexing.
package stepmania_pkg;

    // USB HID usage codes for the default lane keys
    localparam logic [7:0] KEY_LEFT  = 8'h34;
    localparam logic [7:0] KEY_DOWN  = 8'h33;
    localparam logic [7:0] KEY_UP    = 8'h35;
    localparam logic [7:0] KEY_RIGHT = 8'h3b;

    localparam int DEF_NUM_LANES    = 4;
    localparam int DEF_NUM_KEYS     = 2;
    localparam int DEF_LANE_X0      = 256;
    localparam int DEF_LANE_W       = 32;
    localparam int DEF_REC_Y0       = 30;
    localparam int DEF_REC_H        = 50;
    localparam int DEF_FLASH_FRAMES = 6;

    // Lane 0 in the low byte: left, down, up, right
    localparam logic [DEF_NUM_LANES*8-1:0] DEF_LANE_KEYS =
        {KEY_RIGHT, KEY_UP, KEY_DOWN, KEY_LEFT};

    typedef logic [DEF_NUM_LANES-1:0] lane_mask_t;

    function automatic logic is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/lane_flash.sv
// One lane's held level, registered press/release pulses and frame-timed
// flash counter. The counter loads on the registered press pulse.
module lane_flash
    import stepmania_pkg::*;
#(
    parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       i_frame_tick,
    input  logic       i_match,
    output logic       o_held,
    output logic       o_press,
    output logic       o_release,
    output logic [7:0] o_cnt,
    output logic       o_lit
);

    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

    logic       r_held;
    logic       r_press;
    logic       r_release;
    logic [7:0] r_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_held    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_cnt     <= 8'd0;
        end else begin
            r_held    <= i_match;
            r_press   <= i_match & ~r_held;
            r_release <= ~i_match & r_held;
            // A reload on press takes priority over the frame decrement
            if (r_press)
                r_cnt <= FLASH_LOAD;
            else if (i_frame_tick && (r_cnt != 8'd0))
                r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_held    = r_held;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_cnt     = r_cnt;
    assign o_lit     = r_held | (r_cnt != 8'd0);

endmodule

// File: rtl/lane_receptor.sv
// Receptor stage: keycode-to-lane match, per-lane flash state, and registered
// per-pixel lane band / receptor hit flags for the color mapper.
module lane_receptor
    import stepmania_pkg::*;
#(
    parameter int                     NUM_LANES    = DEF_NUM_LANES,
    parameter int                     NUM_KEYS     = DEF_NUM_KEYS,
    parameter logic [NUM_LANES*8-1:0] LANE_KEYS    = DEF_LANE_KEYS,
    parameter int                     LANE_X0      = DEF_LANE_X0,
    parameter int                     LANE_W       = DEF_LANE_W,
    parameter int                     REC_Y0       = DEF_REC_Y0,
    parameter int                     REC_H        = DEF_REC_H,
    parameter int                     FLASH_FRAMES = DEF_FLASH_FRAMES
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_tick,
    input  logic [8*NUM_KEYS-1:0]   keycodes,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    output logic [NUM_LANES-1:0]    key_held,
    output logic [NUM_LANES-1:0]    key_press,
    output logic [NUM_LANES-1:0]    key_release,
    output logic [NUM_LANES-1:0]    is_receptor,
    output logic [7:0]              flash_level,
    output logic                    is_background,
    output logic                    is_receptor_background
);

    // Geometry edges in 11 bits so LANE_X0 + width never wraps
    localparam logic [10:0] X_LO = 11'(LANE_X0);
    localparam logic [10:0] X_HI = 11'(LANE_X0 + NUM_LANES * LANE_W - 1);
    localparam logic [10:0] Y_LO = 11'(REC_Y0);
    localparam logic [10:0] Y_HI = 11'(REC_Y0 + REC_H - 1);

    logic [NUM_LANES-1:0]      w_match;
    logic [NUM_LANES-1:0]      w_lit;
    logic [NUM_LANES-1:0][7:0] w_cnt;
    logic [NUM_LANES-1:0]      w_rec;
    logic [10:0]               w_x;
    logic [10:0]               w_y;
    logic [10:0]               w_off;
    logic [10:0]               w_idx;
    logic                      w_band;
    logic                      w_rows;
    logic [7:0]                w_flash;

    // Duplicated keycodes simply OR into the same lane bit
    always_comb begin
        w_match = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if ((keycodes[8*k +: 8] == LANE_KEYS[8*l +: 8]) &&
                    (keycodes[8*k +: 8] != 8'h00))
                    w_match[l] = 1'b1;
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        lane_flash #(
            .FLASH_FRAMES (FLASH_FRAMES)
        ) u_flash (
            .Clk          (Clk),
            .Reset_n      (Reset_n),
            .i_frame_tick (frame_tick),
            .i_match      (w_match[l]),
            .o_held       (key_held[l]),
            .o_press      (key_press[l]),
            .o_release    (key_release[l]),
            .o_cnt        (w_cnt[l]),
            .o_lit        (w_lit[l])
        );
    end

    assign w_x    = {1'b0, DrawX};
    assign w_y    = {1'b0, DrawY};
    assign w_band = (w_x >= X_LO) && (w_x <= X_HI);
    assign w_rows = (w_y >= Y_LO) && (w_y <= Y_HI);
    assign w_off  = w_x - X_LO;

    if (is_pow2(LANE_W)) begin : g_idx_shift
        assign w_idx = w_off >> $clog2(LANE_W);
    end else begin : g_idx_div
        assign w_idx = w_off / 11'(LANE_W);
    end

    // Lane index is only meaningful inside the band; outside, nothing selects
    always_comb begin
        w_rec   = '0;
        w_flash = 8'd0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_band && (w_idx == 11'(l))) begin
                w_flash  = w_cnt[l];
                w_rec[l] = w_rows & w_lit[l];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_receptor            <= '0;
            flash_level            <= 8'd0;
            is_background          <= 1'b0;
            is_receptor_background <= 1'b0;
        end else begin
            is_receptor            <= w_rec;
            flash_level            <= w_flash;
            is_background          <= w_band;
            is_receptor_background <= w_band & w_rows;
        end
    end

endmodule

// File: tb/tb_lane_receptor.sv
// Directed table-driven bench for lane_receptor: key edges, flash timing,
// geometry boundaries, pixel latency and asynchronous reset.
module tb_lane_receptor;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_tick;
    logic [15:0] keycodes;
    logic [9:0]  DrawX, DrawY;
    logic [3:0]  key_held, key_press, key_release, is_receptor;
    logic [7:0]  flash_level;
    logic        is_background, is_receptor_background;

    int n_vec = 0;
    int n_bad = 0;

    lane_receptor #(
        .NUM_LANES    (4),
        .NUM_KEYS     (2),
        .LANE_KEYS    ({8'h3b, 8'h35, 8'h33, 8'h34}),
        .LANE_X0      (256),
        .LANE_W       (32),
        .REC_Y0       (30),
        .REC_H        (50),
        .FLASH_FRAMES (6)
    ) dut (
        .Clk                    (Clk),
        .Reset_n                (Reset_n),
        .frame_tick             (frame_tick),
        .keycodes               (keycodes),
        .DrawX                  (DrawX),
        .DrawY                  (DrawY),
        .key_held               (key_held),
        .key_press              (key_press),
        .key_release            (key_release),
        .is_receptor            (is_receptor),
        .flash_level            (flash_level),
        .is_background          (is_background),
        .is_receptor_background (is_receptor_background)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] kc;
        logic        ft;
        logic [9:0]  dx, dy;
        logic [3:0]  h, p, r, rec;
        logic [7:0]  flv;
        logic        bg, rbg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] kc, input logic ft,
                       input logic [9:0] dx, input logic [9:0] dy,
                       input logic [3:0] h, input logic [3:0] p,
                       input logic [3:0] r, input logic [3:0] rec,
                       input logic [7:0] flv, input logic bg, input logic rbg);
        vec_t v;
        v.kc = kc; v.ft = ft; v.dx = dx; v.dy = dy;
        v.h = h; v.p = p; v.r = r; v.rec = rec;
        v.flv = flv; v.bg = bg; v.rbg = rbg;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] h, input logic [3:0] p,
                         input logic [3:0] r, input logic [3:0] rec,
                         input logic [7:0] flv, input logic bg, input logic rbg);
        n_vec++;
        if (key_held !== h || key_press !== p || key_release !== r ||
            is_receptor !== rec || flash_level !== flv ||
            is_background !== bg || is_receptor_background !== rbg) begin
            n_bad++;
            $display("FAIL %s: got held=%b press=%b rel=%b rec=%b flv=%0d bg=%b rbg=%b ; want held=%b press=%b rel=%b rec=%b flv=%0d bg=%b rbg=%b",
                     name, key_held, key_press, key_release, is_receptor, flash_level,
                     is_background, is_receptor_background, h, p, r, rec, flv, bg, rbg);
        end
    endtask

    task automatic drive(input logic [15:0] kc, input logic ft,
                         input logic [9:0] dx, input logic [9:0] dy);
        keycodes = kc; frame_tick = ft; DrawX = dx; DrawY = dy;
    endtask

    initial begin
        // Lane 0 press, then release
        add(16'h3400, 0, 0,   0,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h3400, 0, 0,   0,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h3400, 0, 260, 50, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 6, 1, 1);
        add(16'h0000, 0, 0,   0,  4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
        add(16'h0000, 1, 0,   0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        // Two lanes together; lane 3 key moves slots without pulses
        add(16'h333b, 0, 0,   0,  4'b1010, 4'b1010, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h333b, 0, 0,   0,  4'b1010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h3b00, 0, 0,   0,  4'b1000, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0);
        add(16'h003b, 0, 0,   0,  4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h0000, 0, 0,   0,  4'b0000, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0);
        // Lane 2 flash decays over six frame ticks
        add(16'h0035, 0, 0,   0,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h0035, 0, 0,   0,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h0000, 0, 330, 50, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 6, 1, 1);
        for (int i = 6; i >= 1; i--)
            add(16'h0000, 1, 330, 50, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 8'(i), 1, 1);
        add(16'h0000, 0, 330, 50, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);
        // Re-press while cnt=2 with the load coinciding with frame_tick
        add(16'h0035, 0, 0,   0,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h0035, 0, 0,   0,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h0000, 0, 0,   0,  4'b0000, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(16'h0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h0035, 0, 330, 50, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2, 1, 1);
        add(16'h0035, 1, 330, 50, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2, 1, 1);
        // Held past the flash: stays lit once the counter is exhausted
        for (int i = 6; i >= 1; i--)
            add(16'h0035, 1, 330, 50, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 8'(i), 1, 1);
        add(16'h0035, 0, 330, 50, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, 1, 1);
        add(16'h0000, 0, 330, 50, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 0, 1, 1);
        add(16'h0000, 0, 330, 50, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);
        // Geometry sweep with lane 1 held (cnt1=6)
        add(16'h0033, 0, 0,    0,    4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h0033, 0, 0,    0,    4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h0033, 0, 255,  50,   4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h0033, 0, 256,  50,   4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);
        add(16'h0033, 0, 287,  50,   4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);
        add(16'h0033, 0, 288,  50,   4'b0010, 4'b0000, 4'b0000, 4'b0010, 6, 1, 1);
        add(16'h0033, 0, 319,  79,   4'b0010, 4'b0000, 4'b0000, 4'b0010, 6, 1, 1);
        add(16'h0033, 0, 319,  80,   4'b0010, 4'b0000, 4'b0000, 4'b0000, 6, 1, 0);
        add(16'h0033, 0, 300,  30,   4'b0010, 4'b0000, 4'b0000, 4'b0010, 6, 1, 1);
        add(16'h0033, 0, 300,  29,   4'b0010, 4'b0000, 4'b0000, 4'b0000, 6, 1, 0);
        add(16'h0033, 0, 383,  50,   4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);
        add(16'h0033, 0, 384,  50,   4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(16'h3333, 0, 1023, 1023, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

        Reset_n = 1'b0;
        drive(16'h3400, 0, 0, 0);
        repeat (2) @(posedge Clk);
        #1 check("reset", 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0);
        #2 Reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].kc, tbl[i].ft, tbl[i].dx, tbl[i].dy);
            @(posedge Clk);
            #1 check($sformatf("vec%0d", i), tbl[i].h, tbl[i].p, tbl[i].r,
                     tbl[i].rec, tbl[i].flv, tbl[i].bg, tbl[i].rbg);
        end

        // Pixel outputs must not follow DrawX/DrawY before the next edge
        drive(16'h0033, 0, 288, 50);
        #2 check("lat_hold", 4'b0010, 4'b0, 4'b0, 4'b0000, 0, 0, 0);
        @(posedge Clk);
        #1 check("lat_edge", 4'b0010, 4'b0, 4'b0, 4'b0010, 6, 1, 1);

        // Lane 0 held and flashing, then reset asserted mid-cycle
        drive(16'h0034, 0, 260, 50);
        @(posedge Clk);
        #1 check("f_press", 4'b0001, 4'b0001, 4'b0010, 4'b0000, 0, 1, 1);
        @(posedge Clk);
        #1 check("f_held", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 1, 1);
        @(posedge Clk);
        #1 check("f_flash", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 6, 1, 1);
        #2 Reset_n = 1'b0;
        #1 check("f_async", 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0);
        @(posedge Clk);
        #1 check("f_inrst", 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0);
        #2 Reset_n = 1'b1;
        @(posedge Clk);
        #1 check("f_repress", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 1, 1);
        @(posedge Clk);
        #1 check("f_pulse1", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 1, 1);
        @(posedge Clk);
        #1 check("f_reload", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 6, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
